// File: rtl/cpc_keyboard_if.sv
// cpc_keyboard_if: PS/2 key input, matrix row/column port, joystick and control lines of the CPC keyboard.
interface cpc_keyboard_if;
    logic [10:0] ps2_key;
    logic [3:0]  row;
    logic [7:0]  col;
    logic [5:0]  joy;
    logic        clr;
    logic        reset_req;
    modport master (output ps2_key, row, joy, clr, input col, reset_req);
    modport slave (input ps2_key, row, joy, clr, output col, reset_req);
endinterface

// File: rtl/cpc_keyboard.sv
// cpc_keyboard: PS/2 set-2 events to an Amstrad CPC 6128 key matrix with a registered column read port.
// Define CPC_JOY_EN to merge joystick 0 into matrix row 9.
module cpc_keyboard #(
    parameter int KEY_ROWS = 10
) (
    input logic           clk_sys,
    input logic           reset_n,
    cpc_keyboard_if.slave bus
);
    localparam logic [4:0] ROWS = 5'(KEY_ROWS);
    logic [7:0] r_matrix [KEY_ROWS];
    logic       r_armed, r_strobe, r_vld, r_press, r_f12_down, r_reset_req;
    logic [3:0] r_row;
    logic [2:0] r_bit;
    logic [7:0] r_col;
    logic       w_evt, w_hit, w_f12;
    logic [3:0] w_row;
    logic [2:0] w_bit;
    logic [7:0] w_sel, w_joy;
    // r_armed swallows the first strobe sample after reset so a stale toggle is not an event
    assign w_evt = r_armed && (bus.ps2_key[10] != r_strobe);
    assign w_f12 = bus.ps2_key[8:0] == 9'h007;
    always_comb begin
        w_hit = 1'b1;
        {w_row, w_bit} = 7'd0;
        case (bus.ps2_key[8:0])
            9'h175: {w_row, w_bit} = {4'd0, 3'd0};
            9'h174: {w_row, w_bit} = {4'd0, 3'd1};
            9'h172: {w_row, w_bit} = {4'd0, 3'd2};
            9'h16B: {w_row, w_bit} = {4'd1, 3'd0};
            9'h05A: {w_row, w_bit} = {4'd2, 3'd2};
            9'h012: {w_row, w_bit} = {4'd2, 3'd5};
            9'h059: {w_row, w_bit} = {4'd2, 3'd5};
            9'h014: {w_row, w_bit} = {4'd2, 3'd7};
            9'h04D: {w_row, w_bit} = {4'd3, 3'd3};
            9'h045: {w_row, w_bit} = {4'd4, 3'd0};
            9'h046: {w_row, w_bit} = {4'd4, 3'd1};
            9'h044: {w_row, w_bit} = {4'd4, 3'd2};
            9'h043: {w_row, w_bit} = {4'd4, 3'd3};
            9'h04B: {w_row, w_bit} = {4'd4, 3'd4};
            9'h042: {w_row, w_bit} = {4'd4, 3'd5};
            9'h03A: {w_row, w_bit} = {4'd4, 3'd6};
            9'h041: {w_row, w_bit} = {4'd4, 3'd7};
            9'h03E: {w_row, w_bit} = {4'd5, 3'd0};
            9'h03D: {w_row, w_bit} = {4'd5, 3'd1};
            9'h03C: {w_row, w_bit} = {4'd5, 3'd2};
            9'h035: {w_row, w_bit} = {4'd5, 3'd3};
            9'h033: {w_row, w_bit} = {4'd5, 3'd4};
            9'h03B: {w_row, w_bit} = {4'd5, 3'd5};
            9'h031: {w_row, w_bit} = {4'd5, 3'd6};
            9'h029: {w_row, w_bit} = {4'd5, 3'd7};
            9'h036: {w_row, w_bit} = {4'd6, 3'd0};
            9'h02E: {w_row, w_bit} = {4'd6, 3'd1};
            9'h02D: {w_row, w_bit} = {4'd6, 3'd2};
            9'h02C: {w_row, w_bit} = {4'd6, 3'd3};
            9'h034: {w_row, w_bit} = {4'd6, 3'd4};
            9'h02B: {w_row, w_bit} = {4'd6, 3'd5};
            9'h032: {w_row, w_bit} = {4'd6, 3'd6};
            9'h02A: {w_row, w_bit} = {4'd6, 3'd7};
            9'h025: {w_row, w_bit} = {4'd7, 3'd0};
            9'h026: {w_row, w_bit} = {4'd7, 3'd1};
            9'h024: {w_row, w_bit} = {4'd7, 3'd2};
            9'h01D: {w_row, w_bit} = {4'd7, 3'd3};
            9'h01B: {w_row, w_bit} = {4'd7, 3'd4};
            9'h023: {w_row, w_bit} = {4'd7, 3'd5};
            9'h021: {w_row, w_bit} = {4'd7, 3'd6};
            9'h022: {w_row, w_bit} = {4'd7, 3'd7};
            9'h016: {w_row, w_bit} = {4'd8, 3'd0};
            9'h01E: {w_row, w_bit} = {4'd8, 3'd1};
            9'h076: {w_row, w_bit} = {4'd8, 3'd2};
            9'h015: {w_row, w_bit} = {4'd8, 3'd3};
            9'h00D: {w_row, w_bit} = {4'd8, 3'd4};
            9'h01C: {w_row, w_bit} = {4'd8, 3'd5};
            9'h058: {w_row, w_bit} = {4'd8, 3'd6};
            9'h01A: {w_row, w_bit} = {4'd8, 3'd7};
            9'h066: {w_row, w_bit} = {4'd9, 3'd7};
            default: w_hit = 1'b0;
        endcase
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_armed     <= 1'b0;
            r_strobe    <= 1'b0;
            r_vld       <= 1'b0;
            r_press     <= 1'b0;
            r_row       <= '0;
            r_bit       <= '0;
            r_f12_down  <= 1'b0;
            r_reset_req <= 1'b0;
        end else begin
            r_armed     <= 1'b1;
            r_strobe    <= bus.ps2_key[10];
            r_vld       <= w_evt && w_hit && ({1'b0, w_row} < ROWS);
            r_press     <= bus.ps2_key[9];
            r_row       <= w_row;
            r_bit       <= w_bit;
            r_reset_req <= w_evt && w_f12 && bus.ps2_key[9] && !r_f12_down;
            if (w_evt && w_f12) r_f12_down <= bus.ps2_key[9];
        end
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < KEY_ROWS; i++) r_matrix[i] <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < KEY_ROWS; i++) r_matrix[i] <= '0;
        end else if (r_vld) begin
            r_matrix[r_row][r_bit] <= r_press;
        end
    end
`ifdef CPC_JOY_EN
    assign w_joy = (bus.row == 4'd9) ? {2'b00, bus.joy} : 8'h00;
`else
    assign w_joy = 8'h00;
`endif
    assign w_sel = ({1'b0, bus.row} < ROWS) ? ~(r_matrix[bus.row] | w_joy) : 8'hFF;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_col <= 8'hFF;
        else r_col <= w_sel;
    end
    assign bus.col       = r_col;
    assign bus.reset_req = r_reset_req;
endmodule
